// File: rtl/user_mstr_arbiter.sv
// rtl/user_mstr_arbiter.sv - round-robin core-bus arbiter for user masters with enable mask and watchdog
module user_mstr_arbiter #(
  parameter int          NUM_MSTR  = 4,
  parameter int          TIMEOUT_W = 8,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NUM_MSTR-1:0]    mstr_en_i,
  input  logic [NUM_MSTR-1:0]    mstr_valid_i,
  input  logic [NUM_MSTR*32-1:0] mstr_addr_i,
  input  logic [NUM_MSTR*32-1:0] mstr_wdata_i,
  input  logic [NUM_MSTR*4-1:0]  mstr_wstrb_i,
  output logic [NUM_MSTR*32-1:0] mstr_rdata_o,
  output logic [NUM_MSTR-1:0]    mstr_ready_o,
  output logic [NUM_MSTR*32-1:0] mstr_irq_o,
  output logic                   core_valid_o,
  output logic [31:0]            core_addr_o,
  output logic [31:0]            core_wdata_o,
  output logic [3:0]             core_wstrb_o,
  input  logic [31:0]            core_rdata_i,
  input  logic                   core_ready_i,
  input  logic [31:0]            irq_i,
  output logic [NUM_MSTR-1:0]    grant_o,
  output logic                   timeout_o,
  input  logic                   timeout_clr_i
);

  localparam int IDX_W = (NUM_MSTR > 1) ? $clog2(NUM_MSTR) : 1;
  // Watchdog fires when the counter would step onto all-ones, i.e. on the
  // (2^TIMEOUT_W - 1)th stalled BUSY cycle counting the first one as 1.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     gidx;
  logic [TIMEOUT_W-1:0] cnt;

  logic [NUM_MSTR-1:0]  eligible;
  logic [IDX_W-1:0]     pick;
  logic                 found;
  logic                 busy;
  logic                 g_valid;
  logic                 wd_fire;
  logic                 done;

  assign eligible = mstr_valid_i & mstr_en_i;
  assign busy     = (state == BUSY);
  assign g_valid  = mstr_valid_i[gidx];
  // Abort (valid dropped) takes priority over the watchdog; ready beats both.
  assign wd_fire  = busy && !core_ready_i && g_valid && (cnt == CNT_LAST);
  assign done     = busy && (core_ready_i || !g_valid || wd_fire);

  // Round-robin search: first eligible index above the last owner, wrapping.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick  = ptr;
    found = 1'b0;
    for (int off = 1; off <= NUM_MSTR; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_MSTR);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Downstream request is a straight mux from the owner; zero when idle.
  always_comb begin
    core_valid_o = busy && g_valid && !wd_fire;
    core_addr_o  = '0;
    core_wdata_o = '0;
    core_wstrb_o = '0;
    if (busy) begin
      core_addr_o  = mstr_addr_i[{gidx, 5'b0} +: 32];
      core_wdata_o = mstr_wdata_i[{gidx, 5'b0} +: 32];
      core_wstrb_o = mstr_wstrb_i[{gidx, 2'b0} +: 4];
    end
  end

  // Per-master response fan-out and masked interrupt replication.
  always_comb begin
    mstr_ready_o = '0;
    mstr_rdata_o = '0;
    mstr_irq_o   = '0;
    for (int i = 0; i < NUM_MSTR; i++) begin
      mstr_ready_o[i] = busy && (gidx == IDX_W'(i)) && (core_ready_i || wd_fire);
      if (mstr_ready_o[i])
        mstr_rdata_o[i*32 +: 32] = core_ready_i ? core_rdata_i : ERR_RDATA;
      if (rst_n_i && mstr_en_i[i])
        mstr_irq_o[i*32 +: 32] = irq_i;
    end
  end

  // Arbitration FSM, owner tracking, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      grant_o   <= '0;
      gidx      <= '0;
      ptr       <= IDX_W'(NUM_MSTR - 1);
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (wd_fire)
        timeout_o <= 1'b1;
      else if (timeout_clr_i)
        timeout_o <= 1'b0;

      case (state)
        IDLE: begin
          if (found) begin
            state   <= BUSY;
            grant_o <= NUM_MSTR'(1'b1) << pick;
            gidx    <= pick;
            cnt     <= '0;
          end
        end
        BUSY: begin
          if (done) begin
            state   <= IDLE;
            grant_o <= '0;
            ptr     <= gidx;
          end else begin
            cnt <= cnt + TIMEOUT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_mstr_arbiter.sv
// tb/tb_user_mstr_arbiter.sv - directed table-driven bench for user_mstr_arbiter
module tb_user_mstr_arbiter;

  localparam int NM = 4;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [NM-1:0]   mstr_en_i;
  logic [NM-1:0]   mstr_valid_i;
  logic [NM*32-1:0] mstr_addr_i;
  logic [NM*32-1:0] mstr_wdata_i;
  logic [NM*4-1:0]  mstr_wstrb_i;
  logic [NM*32-1:0] mstr_rdata_o;
  logic [NM-1:0]   mstr_ready_o;
  logic [NM*32-1:0] mstr_irq_o;
  logic            core_valid_o;
  logic [31:0]     core_addr_o;
  logic [31:0]     core_wdata_o;
  logic [3:0]      core_wstrb_o;
  logic [31:0]     core_rdata_i;
  logic            core_ready_i;
  logic [31:0]     irq_i;
  logic [NM-1:0]   grant_o;
  logic            timeout_o;
  logic            timeout_clr_i;

  user_mstr_arbiter #(.NUM_MSTR(NM), .TIMEOUT_W(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .mstr_en_i(mstr_en_i), .mstr_valid_i(mstr_valid_i),
    .mstr_addr_i(mstr_addr_i), .mstr_wdata_i(mstr_wdata_i), .mstr_wstrb_i(mstr_wstrb_i),
    .mstr_rdata_o(mstr_rdata_o), .mstr_ready_o(mstr_ready_o), .mstr_irq_o(mstr_irq_o),
    .core_valid_o(core_valid_o), .core_addr_o(core_addr_o), .core_wdata_o(core_wdata_o),
    .core_wstrb_o(core_wstrb_o), .core_rdata_i(core_rdata_i), .core_ready_i(core_ready_i),
    .irq_i(irq_i), .grant_o(grant_o), .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  en;
    logic        rdy;
    logic [31:0] rdata;
    logic [3:0]  egrant;
    logic        ecv;
    int          eown;
    logic [3:0]  erdy;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic [3:0] valid, logic [3:0] en, logic rdy, logic [31:0] rdata,
                              logic [3:0] egrant, logic ecv, int eown, logic [3:0] erdy);
    vec_t v;
    v.valid = valid; v.en = en; v.rdy = rdy; v.rdata = rdata;
    v.egrant = egrant; v.ecv = ecv; v.eown = eown; v.erdy = erdy;
    return v;
  endfunction

  function automatic logic [31:0] addr_of(int i);
    return 32'h1000_0000 + 32'(i * 16);
  endfunction

  function automatic logic [31:0] wdata_of(int i);
    return 32'hA0A0_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Watchdog run on master 1 (write, core never ready until maybe the last cycle).
  task automatic wd_transfer(input logic clr, input logic rdy_last, input logic exp_flag, input string tag);
    mstr_valid_i  = 4'b0010;
    mstr_en_i     = 4'hF;
    core_ready_i  = 1'b0;
    core_rdata_i  = 32'h5555_AAAA;
    timeout_clr_i = clr;
    settle();
    chk({tag, "_idle_grant"}, grant_o, 4'b0000);
    tick();
    for (int c = 1; c <= 15; c++) begin
      core_ready_i = (c == 15) && rdy_last;
      settle();
      chk({tag, "_grant"}, grant_o, 4'b0010);
      chk({tag, "_flag_during"}, timeout_o, 1'b0);
      if (c == 1) begin
        chk({tag, "_wstrb"}, core_wstrb_o, 4'hF);
        chk({tag, "_wdata"}, core_wdata_o, wdata_of(1));
      end
      if (c < 15) begin
        chk({tag, "_ready_early"}, mstr_ready_o, 4'b0000);
        chk({tag, "_cvalid_early"}, core_valid_o, 1'b1);
      end else if (rdy_last) begin
        chk({tag, "_ready_last"}, mstr_ready_o, 4'b0010);
        chk({tag, "_rdata_last"}, mstr_rdata_o, {32'h0, 32'h0, 32'h5555_AAAA, 32'h0});
        chk({tag, "_cvalid_last"}, core_valid_o, 1'b1);
      end else begin
        chk({tag, "_ready_wd"}, mstr_ready_o, 4'b0010);
        chk({tag, "_rdata_wd"}, mstr_rdata_o, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0});
        chk({tag, "_cvalid_wd"}, core_valid_o, 1'b0);
      end
      tick();
    end
    mstr_valid_i = 4'b0000;
    core_ready_i = 1'b0;
    settle();
    chk({tag, "_grant_after"}, grant_o, 4'b0000);
    chk({tag, "_flag_after"}, timeout_o, exp_flag);
    timeout_clr_i = 1'b0;
  endtask

  initial begin
    logic [127:0] exp_rd;
    logic [127:0] exp_irq;
    logic [31:0]  exp_addr;

    rst_n_i = 1'b0;
    mstr_en_i = 4'hF;
    mstr_valid_i = '0;
    core_ready_i = 1'b0;
    core_rdata_i = '0;
    timeout_clr_i = 1'b0;
    irq_i = 32'hFFFF_FFFF;
    for (int i = 0; i < NM; i++) begin
      mstr_addr_i[i*32 +: 32]  = addr_of(i);
      mstr_wdata_i[i*32 +: 32] = wdata_of(i);
      mstr_wstrb_i[i*4 +: 4]   = (i == 1) ? 4'hF : 4'h0;
    end

    vecs[0]  = mk(4'b0001, 4'hF,    1'b0, 32'h0,         4'b0000, 1'b0, -1, 4'b0000);
    vecs[1]  = mk(4'b0001, 4'hF,    1'b0, 32'h0,         4'b0001, 1'b1,  0, 4'b0000);
    vecs[2]  = mk(4'b0001, 4'hF,    1'b0, 32'h0,         4'b0001, 1'b1,  0, 4'b0000);
    vecs[3]  = mk(4'b0001, 4'hF,    1'b1, 32'h1234_5678, 4'b0001, 1'b1,  0, 4'b0001);
    vecs[4]  = mk(4'b0000, 4'hF,    1'b0, 32'h0,         4'b0000, 1'b0, -1, 4'b0000);
    vecs[5]  = mk(4'b0000, 4'hF,    1'b1, 32'hCAFE_0000, 4'b0000, 1'b0, -1, 4'b0000);
    vecs[6]  = mk(4'b1111, 4'hF,    1'b1, 32'h1111_0001, 4'b0000, 1'b0, -1, 4'b0000);
    vecs[7]  = mk(4'b1111, 4'hF,    1'b1, 32'h1111_0002, 4'b0010, 1'b1,  1, 4'b0010);
    vecs[8]  = mk(4'b1111, 4'hF,    1'b1, 32'h1111_0003, 4'b0000, 1'b0, -1, 4'b0000);
    vecs[9]  = mk(4'b1111, 4'hF,    1'b1, 32'h1111_0004, 4'b0100, 1'b1,  2, 4'b0100);
    vecs[10] = mk(4'b1111, 4'hF,    1'b1, 32'h1111_0005, 4'b0000, 1'b0, -1, 4'b0000);
    vecs[11] = mk(4'b1111, 4'hF,    1'b1, 32'h1111_0006, 4'b1000, 1'b1,  3, 4'b1000);
    vecs[12] = mk(4'b1111, 4'hF,    1'b1, 32'h1111_0007, 4'b0000, 1'b0, -1, 4'b0000);
    vecs[13] = mk(4'b1111, 4'hF,    1'b1, 32'h1111_0008, 4'b0001, 1'b1,  0, 4'b0001);
    vecs[14] = mk(4'b1111, 4'b1011, 1'b1, 32'h2222_0001, 4'b0000, 1'b0, -1, 4'b0000);
    vecs[15] = mk(4'b1111, 4'b1011, 1'b1, 32'h2222_0002, 4'b0010, 1'b1,  1, 4'b0010);
    vecs[16] = mk(4'b1111, 4'b1011, 1'b1, 32'h2222_0003, 4'b0000, 1'b0, -1, 4'b0000);
    vecs[17] = mk(4'b1111, 4'b1011, 1'b1, 32'h2222_0004, 4'b1000, 1'b1,  3, 4'b1000);
    vecs[18] = mk(4'b1111, 4'b1011, 1'b1, 32'h2222_0005, 4'b0000, 1'b0, -1, 4'b0000);
    vecs[19] = mk(4'b1111, 4'b1011, 1'b1, 32'h2222_0006, 4'b0001, 1'b1,  0, 4'b0001);
    vecs[20] = mk(4'b1111, 4'b1011, 1'b1, 32'h2222_0007, 4'b0000, 1'b0, -1, 4'b0000);
    vecs[21] = mk(4'b1111, 4'b1011, 1'b1, 32'h2222_0008, 4'b0010, 1'b1,  1, 4'b0010);
    vecs[22] = mk(4'b0000, 4'hF,    1'b0, 32'h0,         4'b0000, 1'b0, -1, 4'b0000);

    // Reset state
    #2;
    chk("rst_grant", grant_o, 4'b0000);
    chk("rst_cvalid", core_valid_o, 1'b0);
    chk("rst_ready", mstr_ready_o, 4'b0000);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_irq", mstr_irq_o, 128'h0);
    tick();
    tick();
    rst_n_i = 1'b1;

    // Table: single read, idle-ready ignored, round robin, enable mask
    for (int k = 0; k < 23; k++) begin
      mstr_valid_i = vecs[k].valid;
      mstr_en_i    = vecs[k].en;
      core_ready_i = vecs[k].rdy;
      core_rdata_i = vecs[k].rdata;
      settle();
      exp_addr = (vecs[k].eown < 0) ? 32'h0 : addr_of(vecs[k].eown);
      for (int i = 0; i < NM; i++) begin
        exp_rd[i*32 +: 32]  = vecs[k].erdy[i] ? vecs[k].rdata : 32'h0;
        exp_irq[i*32 +: 32] = vecs[k].en[i] ? irq_i : 32'h0;
      end
      chk($sformatf("v%0d_grant", k), grant_o, vecs[k].egrant);
      chk($sformatf("v%0d_cvalid", k), core_valid_o, vecs[k].ecv);
      chk($sformatf("v%0d_addr", k), core_addr_o, exp_addr);
      chk($sformatf("v%0d_ready", k), mstr_ready_o, vecs[k].erdy);
      chk($sformatf("v%0d_rdata", k), mstr_rdata_o, exp_rd);
      chk($sformatf("v%0d_irq", k), mstr_irq_o, exp_irq);
      tick();
    end

    // Watchdog: fire then clear; ready wins on the terminal cycle; set beats clear
    wd_transfer(1'b0, 1'b0, 1'b1, "wd_fire");
    tick();
    settle();
    chk("wd_flag_sticky", timeout_o, 1'b1);
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    settle();
    chk("wd_flag_cleared", timeout_o, 1'b0);
    wd_transfer(1'b0, 1'b1, 1'b0, "wd_ready_wins");
    wd_transfer(1'b1, 1'b0, 1'b1, "wd_set_over_clr");

    // Abort: master 2 drops valid mid-transfer, master 3 goes next
    mstr_valid_i = 4'b0100;
    tick();
    settle();
    chk("ab_grant", grant_o, 4'b0100);
    chk("ab_cvalid", core_valid_o, 1'b1);
    chk("ab_addr", core_addr_o, addr_of(2));
    tick();
    mstr_valid_i = 4'b1000;
    settle();
    chk("ab_drop_ready", mstr_ready_o, 4'b0000);
    chk("ab_drop_cvalid", core_valid_o, 1'b0);
    tick();
    settle();
    chk("ab_idle_grant", grant_o, 4'b0000);
    chk("ab_idle_ready", mstr_ready_o, 4'b0000);
    tick();
    core_ready_i = 1'b1;
    core_rdata_i = 32'h3333_0003;
    settle();
    chk("ab_next_grant", grant_o, 4'b1000);
    chk("ab_next_ready", mstr_ready_o, 4'b1000);
    tick();
    mstr_valid_i = 4'b0000;
    core_ready_i = 1'b0;

    // Master 1 transfer (pointer moves to 1), then reset mid-BUSY on master 2
    mstr_valid_i = 4'b0010;
    tick();
    core_ready_i = 1'b1;
    settle();
    chk("pre_rst_grant", grant_o, 4'b0010);
    tick();
    core_ready_i = 1'b0;
    mstr_valid_i = 4'b0100;
    tick();
    settle();
    chk("pre_rst_busy", core_valid_o, 1'b1);
    chk("pre_rst_flag", timeout_o, 1'b1);
    rst_n_i = 1'b0;
    #1;
    chk("arst_cvalid", core_valid_o, 1'b0);
    chk("arst_grant", grant_o, 4'b0000);
    chk("arst_addr", core_addr_o, 32'h0);
    chk("arst_ready", mstr_ready_o, 4'b0000);
    chk("arst_timeout", timeout_o, 1'b0);
    chk("arst_irq", mstr_irq_o, 128'h0);
    tick();
    rst_n_i = 1'b1;
    mstr_valid_i = 4'b1111;
    settle();
    chk("post_rst_idle", grant_o, 4'b0000);
    tick();
    settle();
    chk("post_rst_first", grant_o, 4'b0001);
    mstr_valid_i = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
